sbb_profiler: RTL and testbench

Parametrised short-backward-branch (SBB) profiler for the RCA subsystem. It watches resolved branches from the CPU branch unit and keeps a small fully-associative table of loop-closing branches with saturating taken counters. It reports each loop that crosses the taken threshold to the RCA PR request logic through a valid/ready candidate port. Compared with the earlier fixed-size profiler, it adds parametrised table depth and widths, periodic counter decay, min-count replacement, explicit entry clearing and a drop counter.

---
 rtl/sbb_profiler.sv | 241 ++++++++++++++++++++++++
 tb/tb_sbb_profiler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbb_profiler.sv
// sbb_profiler: fully-associative table of short backward (loop-closing)
// branches with saturating taken counters, periodic decay, min-count
// replacement and a registered valid/ready candidate port.

// One table entry; owns its own next-state logic. Priority: clr > alloc > update.
module sbb_profiler_entry #(
  parameter int ADDR_W                = 32,
  parameter int CNT_W                 = 9,
  parameter int MAX_TAKEN_COUNT       = 256,
  parameter int TAKEN_COUNT_THRESHOLD = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              decay,
  input  logic              clr,
  input  logic              inc,
  input  logic              alloc,
  input  logic              ack,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic [ADDR_W-1:0] new_target,
  output logic              valid,
  output logic              valid_nxt,
  output logic              pending,
  output logic              reported,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] target,
  output logic [CNT_W-1:0]  cnt
);
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(MAX_TAKEN_COUNT);
  localparam logic [CNT_W-1:0] THR  = CNT_W'(TAKEN_COUNT_THRESHOLD);

  logic [CNT_W-1:0]  d_cnt, i_cnt, cnt_n;
  logic              pend_n, rep_n;
  logic [ADDR_W-1:0] pc_n, tgt_n;

  // Next state: decay halves first, a same-cycle hit then adds one on top.
  always_comb begin
    d_cnt     = decay ? (cnt >> 1) : cnt;
    i_cnt     = (d_cnt >= CMAX) ? CMAX : d_cnt + CNT_W'(1);
    valid_nxt = valid;
    pend_n    = pending;
    rep_n     = reported;
    cnt_n     = cnt;
    pc_n      = pc;
    tgt_n     = target;
    if (clr) begin
      valid_nxt = 1'b0;
      pend_n    = 1'b0;
      rep_n     = 1'b0;
      cnt_n     = '0;
    end else if (alloc) begin
      valid_nxt = 1'b1;
      pc_n      = new_pc;
      tgt_n     = new_target;
      cnt_n     = CNT_W'(1);
      // allocation moves the count 0 -> 1, a crossing only when T is 1
      pend_n    = (TAKEN_COUNT_THRESHOLD == 1);
      rep_n     = 1'b0;
    end else if (valid) begin
      cnt_n = d_cnt;
      if (inc) begin
        cnt_n = i_cnt;
        if (d_cnt < THR && i_cnt >= THR && !reported) pend_n = 1'b1;
      end
      if (ack) begin
        pend_n = 1'b0;
        rep_n  = 1'b1;
      end
      // decayed to zero and nothing owed to the consumer: free the slot
      if (decay && !inc && d_cnt == '0 && !pending) valid_nxt = 1'b0;
    end
  end

  // Entry state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      pending  <= 1'b0;
      reported <= 1'b0;
      cnt      <= '0;
      pc       <= '0;
      target   <= '0;
    end else begin
      valid    <= valid_nxt;
      pending  <= pend_n;
      reported <= rep_n;
      cnt      <= cnt_n;
      pc       <= pc_n;
      target   <= tgt_n;
    end
  end
endmodule

module sbb_profiler #(
  parameter int NUM_ENTRIES           = 4,
  parameter int ADDR_W                = 32,
  parameter int OFFSET_W              = 20,
  parameter int SBB_MAX_OFFSET        = -32,
  parameter int MAX_TAKEN_COUNT       = 256,
  parameter int TAKEN_COUNT_THRESHOLD = 20,
  parameter int DECAY_PERIOD          = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic                               br_valid,
  input  logic                               br_taken,
  input  logic [ADDR_W-1:0]                  br_pc,
  input  logic [OFFSET_W-1:0]                br_offset,
  input  logic                               clr_valid,
  input  logic [ADDR_W-1:0]                  clr_pc,
  output logic                               cand_valid,
  input  logic                               cand_ready,
  output logic [ADDR_W-1:0]                  cand_pc,
  output logic [ADDR_W-1:0]                  cand_target,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy,
  output logic [15:0]                        drop_count
);
  localparam int CNT_W = $clog2(MAX_TAKEN_COUNT+1);
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int OCC_W = $clog2(NUM_ENTRIES+1);
  localparam int DEC_W = $clog2(DECAY_PERIOD);
  localparam logic signed [OFFSET_W-1:0] MAX_OFF = OFFSET_W'(SBB_MAX_OFFSET);

  logic [NUM_ENTRIES-1:0]             e_valid, e_pend, e_rep, vnx;
  logic [NUM_ENTRIES-1:0]             m_br, m_clr, inc, alloc, ack, evictable;
  logic [NUM_ENTRIES-1:0][ADDR_W-1:0] e_pc, e_tgt;
  logic [NUM_ENTRIES-1:0][CNT_W-1:0]  e_cnt;

  logic              sbb, decay, any_hit, free_found, vic_found, nx_found;
  logic [IDX_W-1:0]  free_idx, vic_idx, nx_idx, cand_idx;
  logic [CNT_W-1:0]  vic_cnt;
  logic [NUM_ENTRIES-1:0] nx_mask;
  logic [ADDR_W-1:0] br_tgt;
  logic [DEC_W-1:0]  dec_cnt;
  logic [OCC_W-1:0]  occ_n;

  assign sbb     = enable && br_valid && br_taken && br_offset[OFFSET_W-1] &&
                   ($signed(br_offset) >= MAX_OFF);
  assign br_tgt  = br_pc + ADDR_W'($signed(br_offset));
  assign decay   = (dec_cnt == '1);
  assign any_hit = |m_br;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
    assign m_br[g]      = e_valid[g] && (e_pc[g] == br_pc);
    assign m_clr[g]     = clr_valid && e_valid[g] && (e_pc[g] == clr_pc);
    // a hit on an entry being cleared is swallowed, never reallocated
    assign inc[g]       = sbb && m_br[g] && !m_clr[g];
    assign evictable[g] = e_valid[g] && !e_pend[g] && !e_rep[g] && !m_clr[g];
    assign alloc[g]     = sbb && !any_hit &&
                          (free_found ? (free_idx == IDX_W'(g))
                                      : (vic_found && vic_idx == IDX_W'(g)));
    assign ack[g]       = cand_valid && cand_ready && (cand_idx == IDX_W'(g));

    sbb_profiler_entry #(
      .ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_TAKEN_COUNT(MAX_TAKEN_COUNT),
      .TAKEN_COUNT_THRESHOLD(TAKEN_COUNT_THRESHOLD)
    ) u_ent (
      .clk(clk), .rst_n(rst_n), .decay(decay), .clr(m_clr[g]), .inc(inc[g]),
      .alloc(alloc[g]), .ack(ack[g]), .new_pc(br_pc), .new_target(br_tgt),
      .valid(e_valid[g]), .valid_nxt(vnx[g]), .pending(e_pend[g]),
      .reported(e_rep[g]), .pc(e_pc[g]), .target(e_tgt[g]), .cnt(e_cnt[g])
    );
  end

  // Slot choice: lowest free slot, else lowest-index minimum-count evictable.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    vic_found  = 1'b0;
    vic_idx    = '0;
    vic_cnt    = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!e_valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (evictable[i] && (!vic_found || e_cnt[i] < vic_cnt)) begin
        vic_found = 1'b1;
        vic_idx   = IDX_W'(i);
        vic_cnt   = e_cnt[i];
      end
    end
  end

  // Next candidate: lowest pending entry, skipping the one being handed off or cleared.
  always_comb begin
    nx_mask = e_pend & ~m_clr;
    if (cand_valid) nx_mask[cand_idx] = 1'b0;
    nx_found = 1'b0;
    nx_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (nx_mask[i] && !nx_found) begin
        nx_found = 1'b1;
        nx_idx   = IDX_W'(i);
      end
    end
  end

  // Valid-entry count of the table as it will look after this edge.
  always_comb begin
    occ_n = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) occ_n = occ_n + OCC_W'(vnx[i]);
  end

  // Candidate port, decay timer, occupancy and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_valid  <= 1'b0;
      cand_idx    <= '0;
      cand_pc     <= '0;
      cand_target <= '0;
      dec_cnt     <= '0;
      occupancy   <= '0;
      drop_count  <= '0;
    end else begin
      dec_cnt   <= dec_cnt + DEC_W'(1);
      occupancy <= occ_n;
      if (sbb && !any_hit && !free_found && !vic_found && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
      if (cand_valid) begin
        // clearing the presented entry withdraws it; the next one waits a cycle
        if (m_clr[cand_idx]) begin
          cand_valid <= 1'b0;
        end else if (cand_ready) begin
          cand_valid <= nx_found;
          if (nx_found) begin
            cand_idx    <= nx_idx;
            cand_pc     <= e_pc[nx_idx];
            cand_target <= e_tgt[nx_idx];
          end
        end
      end else if (nx_found) begin
        cand_valid  <= 1'b1;
        cand_idx    <= nx_idx;
        cand_pc     <= e_pc[nx_idx];
        cand_target <= e_tgt[nx_idx];
      end
    end
  end
endmodule

// File: tb/tb_sbb_profiler.sv
// tb_sbb_profiler: directed scoreboard bench. Instance a uses default
// parameters; instance b uses DECAY_PERIOD=16, threshold 10 for decay cases.
module tb_sbb_profiler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] tgt; } cand_t;
  cand_t qa[$];
  cand_t qb[$];
  int checks = 0;
  int failures = 0;

  logic        a_rst_n, a_en, a_bv, a_bt, a_clv, a_cv, a_cr;
  logic [31:0] a_bpc, a_clpc, a_cpc, a_ctg;
  logic [19:0] a_boff;
  logic [2:0]  a_occ;
  logic [15:0] a_drop;
  logic        b_rst_n, b_en, b_bv, b_bt, b_clv, b_cv, b_cr;
  logic [31:0] b_bpc, b_clpc, b_cpc, b_ctg;
  logic [19:0] b_boff;
  logic [2:0]  b_occ;
  logic [15:0] b_drop;

  sbb_profiler u_a (
    .clk(clk), .rst_n(a_rst_n), .enable(a_en), .br_valid(a_bv), .br_taken(a_bt),
    .br_pc(a_bpc), .br_offset(a_boff), .clr_valid(a_clv), .clr_pc(a_clpc),
    .cand_valid(a_cv), .cand_ready(a_cr), .cand_pc(a_cpc), .cand_target(a_ctg),
    .occupancy(a_occ), .drop_count(a_drop));

  sbb_profiler #(.DECAY_PERIOD(16), .TAKEN_COUNT_THRESHOLD(10)) u_b (
    .clk(clk), .rst_n(b_rst_n), .enable(b_en), .br_valid(b_bv), .br_taken(b_bt),
    .br_pc(b_bpc), .br_offset(b_boff), .clr_valid(b_clv), .clr_pc(b_clpc),
    .cand_valid(b_cv), .cand_ready(b_cr), .cand_pc(b_cpc), .cand_target(b_ctg),
    .occupancy(b_occ), .drop_count(b_drop));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitors: every handshake pops and compares one expectation.
  always @(negedge clk) begin
    if (a_rst_n && a_cv && a_cr) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_cand actual_pc=0x%0h expected=none", a_cpc);
      end else begin
        cand_t e;
        e = qa.pop_front();
        chk("a_sb_pc", a_cpc, e.pc);
        chk("a_sb_target", a_ctg, e.tgt);
      end
    end
  end

  always @(negedge clk) begin
    if (b_rst_n && b_cv && b_cr) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_cand actual_pc=0x%0h expected=none", b_cpc);
      end else begin
        cand_t e;
        e = qb.pop_front();
        chk("b_sb_pc", b_cpc, e.pc);
        chk("b_sb_target", b_ctg, e.tgt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br_a(input logic [31:0] pc, input int off, input logic tk);
    a_bv = 1'b1; a_bt = tk; a_bpc = pc; a_boff = 20'(off);
    tick();
    a_bv = 1'b0;
  endtask

  task automatic hits_a(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) br_a(pc, -16, 1'b1);
  endtask

  task automatic hits_b(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) begin
      b_bv = 1'b1; b_bt = 1'b1; b_bpc = pc; b_boff = 20'hFFFF0;
      tick();
      b_bv = 1'b0;
    end
  endtask

  task automatic push_a(input logic [31:0] pc);
    cand_t e;
    e.pc = pc; e.tgt = pc - 32'd16;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] pc);
    cand_t e;
    e.pc = pc; e.tgt = pc - 32'd16;
    qb.push_back(e);
  endtask

  task automatic hs_a();
    a_cr = 1'b1; tick(); a_cr = 1'b0;
  endtask

  task automatic hs_b();
    b_cr = 1'b1; tick(); b_cr = 1'b0;
  endtask

  // One edge after a crossing event the candidate must be on the port.
  task automatic see_a(input string nm, input logic [31:0] pc);
    tick();
    chk({nm, "_valid"}, a_cv, 1);
    chk({nm, "_pc"}, a_cpc, pc);
  endtask

  task automatic reset_a();
    a_rst_n = 1'b0;
    repeat (3) tick();
    a_rst_n = 1'b1;
  endtask

  task automatic reset_b();
    b_rst_n = 1'b0;
    repeat (3) tick();
    b_rst_n = 1'b1;
  endtask

  initial begin
    a_rst_n = 0; a_en = 1; a_bv = 0; a_bt = 0; a_bpc = 0; a_boff = 0;
    a_clv = 0; a_clpc = 0; a_cr = 0;
    b_rst_n = 0; b_en = 1; b_bv = 0; b_bt = 0; b_bpc = 0; b_boff = 0;
    b_clv = 0; b_clpc = 0; b_cr = 0;

    // reset state
    a_rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_cand_valid", a_cv, 0);
    chk("rst_cand_pc", a_cpc, 0);
    chk("rst_cand_target", a_ctg, 0);
    chk("rst_occupancy", a_occ, 0);
    chk("rst_drop", a_drop, 0);
    a_rst_n = 1'b1;

    // threshold crossing, hold while not ready, single report
    push_a(32'h100);
    hits_a(32'h100, 20);
    chk("main_not_early", a_cv, 0);
    chk("main_occ", a_occ, 1);
    tick();
    chk("main_valid", a_cv, 1);
    chk("main_pc", a_cpc, 32'h100);
    chk("main_target", a_ctg, 32'hF0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", a_cv, 1);
      chk("hold_pc", a_cpc, 32'h100);
      chk("hold_target", a_ctg, 32'hF0);
    end
    a_cr = 1'b1;
    tick();
    chk("after_hs_valid", a_cv, 0);
    hits_a(32'h100, 10);
    tick();
    chk("no_second_cand", a_cv, 0);
    a_cr = 1'b0;

    // non-qualifying events and the offset boundary
    reset_a();
    br_a(32'h200, -40, 1'b1);
    chk("nq_far_offset", a_occ, 0);
    br_a(32'h200, 8, 1'b1);
    chk("nq_forward", a_occ, 0);
    br_a(32'h200, -16, 1'b0);
    chk("nq_not_taken", a_occ, 0);
    a_en = 1'b0;
    br_a(32'h200, -16, 1'b1);
    chk("nq_disabled", a_occ, 0);
    a_en = 1'b1;
    br_a(32'h200, -33, 1'b1);
    chk("nq_minus33", a_occ, 0);
    br_a(32'h200, -32, 1'b1);
    chk("edge_minus32", a_occ, 1);

    // min-count eviction and drop
    reset_a();
    hits_a(32'h1000, 5);
    hits_a(32'h1010, 2);
    hits_a(32'h1020, 7);
    hits_a(32'h1030, 2);
    chk("fill_occ", a_occ, 4);
    hits_a(32'h1040, 1);
    chk("evict_occ", a_occ, 4);
    push_a(32'h1030);
    hits_a(32'h1030, 18);
    see_a("evict_idx3_kept", 32'h1030);
    hs_a();
    hits_a(32'h1040, 18);
    tick();
    chk("evict_new_cnt1", a_cv, 0);
    push_a(32'h1040);
    hits_a(32'h1040, 1);
    see_a("evict_new_cand", 32'h1040);
    hs_a();
    push_a(32'h1000);
    hits_a(32'h1000, 15);
    see_a("fill_p0", 32'h1000);
    hs_a();
    push_a(32'h1020);
    hits_a(32'h1020, 13);
    see_a("fill_p2", 32'h1020);
    hs_a();
    chk("drop_before", a_drop, 0);
    hits_a(32'h1050, 1);
    chk("drop_after", a_drop, 1);
    chk("drop_occ", a_occ, 4);

    // clear the presented candidate, next pending follows a cycle later
    reset_a();
    hits_a(32'h300, 20);
    push_a(32'h400);
    hits_a(32'h400, 20);
    chk("clr_pre_pc", a_cpc, 32'h300);
    a_clv = 1'b1; a_clpc = 32'h300;
    tick();
    a_clv = 1'b0;
    chk("clr_valid_drop", a_cv, 0);
    chk("clr_occ", a_occ, 1);
    tick();
    chk("clr_next_valid", a_cv, 1);
    chk("clr_next_pc", a_cpc, 32'h400);
    chk("clr_next_target", a_ctg, 32'h3F0);
    hs_a();

    // reset in the middle of a handshake
    reset_a();
    hits_a(32'h500, 20);
    tick();
    chk("mid_rst_pre", a_cv, 1);
    a_cr = 1'b1; a_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", a_cv, 0);
    chk("mid_rst_pc", a_cpc, 0);
    chk("mid_rst_occ", a_occ, 0);
    a_cr = 1'b0;
    repeat (2) tick();
    a_rst_n = 1'b1;

    // decay: 9 -> 4, 1 -> invalid (edges counted from reset release)
    reset_b();
    hits_b(32'h800, 9);            // edges 1..9
    hits_b(32'h900, 1);            // edge 10
    chk("dec_occ_pre", b_occ, 2);
    repeat (5) tick();             // edges 11..15
    chk("dec_occ_hold", b_occ, 2);
    tick();                        // edge 16: wrap
    chk("dec_occ_post", b_occ, 1);
    hits_b(32'h800, 5);            // edges 17..21, count 9
    push_b(32'h800);
    hits_b(32'h800, 1);            // edge 22, count 10
    chk("dec_not_early", b_cv, 0);
    tick();
    chk("dec_cand_valid", b_cv, 1);
    chk("dec_cand_pc", b_cpc, 32'h800);
    hs_b();

    // hit on the wrap cycle from 9 gives 5
    reset_b();
    repeat (6) tick();             // edges 1..6
    hits_b(32'hA00, 9);            // edges 7..15
    hits_b(32'hA00, 1);            // edge 16: (9>>1)+1
    hits_b(32'hA00, 4);            // edges 17..20, count 9
    tick();                        // edge 21
    chk("wrap_hit_short", b_cv, 0);
    chk("wrap_hit_occ", b_occ, 1);
    push_b(32'hA00);
    hits_b(32'hA00, 1);            // edge 22, count 10
    chk("wrap_hit_not_early", b_cv, 0);
    tick();
    chk("wrap_hit_cand", b_cv, 1);
    chk("wrap_hit_pc", b_cpc, 32'hA00);
    hs_b();

    tick();
    chk("sb_a_drained", qa.size(), 0);
    chk("sb_b_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
